// File: rtl/otter_io_bus.sv
// otter_io_bus: memory-mapped I/O block for the OTTER MCU.
// Provides synchronized board inputs, CPU-writable output registers and
// a debounced, maskable interrupt controller with write-1-to-clear status.
module otter_io_bus #(
  parameter int          N_IN      = 2,
  parameter int          N_OUT     = 3,
  parameter int          DW        = 16,
  parameter int          N_IRQ     = 5,
  parameter int          DB_CYCLES = 5,
  parameter logic [31:0] IN_BASE   = 32'h11008000,
  parameter logic [31:0] OUT_BASE  = 32'h1100C000
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic [31:0]           iobus_addr,
  input  logic [31:0]           iobus_out,
  input  logic                  iobus_wr,
  output logic [31:0]           iobus_in,
  input  logic [N_IN*DW-1:0]    in_data,
  input  logic [N_IRQ-1:0]      irq_src,
  output logic [N_OUT*DW-1:0]   out_data,
  output logic                  intr
);

  localparam logic [31:0] STAT_ADDR = IN_BASE + 32'(4 * N_IN);
  localparam logic [31:0] MASK_ADDR = OUT_BASE + 32'(4 * N_OUT);
  localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);

  logic [N_IN*DW-1:0]          in_s1;
  logic [N_IN*DW-1:0]          in_s2;
  logic [N_IRQ-1:0]            irq_s1;
  logic [N_IRQ-1:0]            irq_s2;
  logic [N_IRQ-1:0]            db_level;
  logic [N_IRQ-1:0][7:0]       db_cnt;
  logic [N_IRQ-1:0]            db_toggle;
  logic [N_IRQ-1:0]            db_rise;
  logic [N_IRQ-1:0]            irq_stat;
  logic [N_IRQ-1:0]            irq_mask;
  logic [N_IRQ-1:0]            stat_clr;
  logic [N_OUT-1:0][DW-1:0]    out_reg;
  logic                        stat_hit;
  logic                        mask_hit;
  logic                        unused_wdata;

  assign stat_hit     = (iobus_addr == STAT_ADDR);
  assign mask_hit     = (iobus_addr == MASK_ADDR);
  assign stat_clr     = (iobus_wr && stat_hit) ? iobus_out[N_IRQ-1:0] : '0;
  assign out_data     = out_reg;
  assign unused_wdata = ^iobus_out;

  // Two-flop synchronizers for every asynchronous board input and IRQ line
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      in_s1  <= '0;
      in_s2  <= '0;
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      in_s1  <= in_data;
      in_s2  <= in_s1;
      irq_s1 <= irq_src;
      irq_s2 <= irq_s1;
    end
  end

  // Detect the edge on which a channel's debounced level will flip
  always_comb begin
    db_toggle = '0;
    db_rise   = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      db_toggle[i] = (irq_s2[i] != db_level[i]) && (db_cnt[i] == DB_LAST);
      db_rise[i]   = db_toggle[i] && !db_level[i];
    end
  end

  // Per-channel debounce counters and debounced levels
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      db_cnt   <= '0;
      db_level <= '0;
    end else begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (irq_s2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_toggle[i]) begin
          db_cnt[i]   <= '0;
          db_level[i] <= ~db_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Interrupt status (sticky, W1C, set wins), mask and registered request
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      irq_stat <= '0;
      irq_mask <= '0;
      intr     <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~stat_clr) | db_rise;
      if (iobus_wr && mask_hit) irq_mask <= iobus_out[N_IRQ-1:0];
      intr <= |(irq_stat & irq_mask);
    end
  end

  // CPU-writable output registers
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      out_reg <= '0;
    end else if (iobus_wr) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (iobus_addr == OUT_BASE + 32'(4 * k)) out_reg[k] <= iobus_out[DW-1:0];
      end
    end
  end

  // Combinational read mux; unmapped addresses read as zero
  always_comb begin
    iobus_in = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (iobus_addr == IN_BASE + 32'(4 * k)) iobus_in = 32'(in_s2[k*DW +: DW]);
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (iobus_addr == OUT_BASE + 32'(4 * k)) iobus_in = 32'(out_reg[k]);
    end
    if (stat_hit) iobus_in = 32'(irq_stat);
    if (mask_hit) iobus_in = 32'(irq_mask);
  end

endmodule

// File: tb/tb_otter_io_bus.sv
// Self-checking bench for otter_io_bus with a cycle-level behavioural model.
module tb_otter_io_bus;

  localparam int          DB   = 5;
  localparam logic [31:0] IB   = 32'h11008000;
  localparam logic [31:0] OB   = 32'h1100C000;
  localparam logic [31:0] STAT = IB + 32'd8;
  localparam logic [31:0] MASK = OB + 32'd12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] rdata;
  logic [31:0] in_data;
  logic [4:0]  irq_src;
  logic [47:0] out_data;
  logic        intr;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  logic [2:0][15:0] m_out;
  logic [4:0]       m_mask, m_stat, m_db, m_irq1, m_irq2;
  logic             m_intr;
  logic [31:0]      m_in1, m_in2;
  int               m_run [5];

  otter_io_bus dut (
    .clk(clk), .RST_N(rst_n), .iobus_addr(addr), .iobus_out(wdata),
    .iobus_wr(wr), .iobus_in(rdata), .in_data(in_data), .irq_src(irq_src),
    .out_data(out_data), .intr(intr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_step();
    logic [4:0] rise;
    logic       n_intr;
    if (!rst_n) begin
      m_out = '0; m_mask = '0; m_stat = '0; m_db = '0; m_intr = 1'b0;
      m_irq1 = '0; m_irq2 = '0; m_in1 = '0; m_in2 = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
    end else begin
      rise   = '0;
      n_intr = |(m_stat & m_mask);
      for (int i = 0; i < 5; i++) begin
        if (m_irq2[i] !== m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_db[i]  = ~m_db[i];
            m_run[i] = 0;
            rise[i]  = m_db[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (wr && addr == STAT) m_stat = m_stat & ~wdata[4:0];
      m_stat = m_stat | rise;
      if (wr) begin
        for (int k = 0; k < 3; k++) if (addr == OB + 32'(4 * k)) m_out[k] = wdata[15:0];
        if (addr == MASK) m_mask = wdata[4:0];
      end
      m_irq2 = m_irq1; m_irq1 = irq_src;
      m_in2  = m_in1;  m_in1  = in_data;
      m_intr = n_intr;
    end
  endtask

  // Expected read data for an address given the model state
  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == IB)        r = {16'h0, m_in2[15:0]};
    if (a == IB + 32'd4) r = {16'h0, m_in2[31:16]};
    if (a == STAT)      r = {27'h0, m_stat};
    if (a == OB)        r = {16'h0, m_out[0]};
    if (a == OB + 32'd4) r = {16'h0, m_out[1]};
    if (a == OB + 32'd8) r = {16'h0, m_out[2]};
    if (a == MASK)      r = {27'h0, m_mask};
    return r;
  endfunction

  // One clock: update model, wait for the edge, settle past it
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] tbl [10];
    tbl = '{IB, IB + 32'd4, STAT, OB, OB + 32'd4, OB + 32'd8, MASK,
            32'h11008100, OB + 32'd2, 32'h0};
    return tbl[$urandom_range(0, 9)];
  endfunction

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    wr = w; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = $urandom;
    irq_src = 5'h1f;
    applyStimulus(1'b1, OB + 32'd4, 32'h0000FFFF);
    tick(); tick();
    vectors++;
    if (out_data !== 48'h0) begin errors++; $display("[TB] FAIL reset_out actual=%h required=0", out_data); end
    vectors++;
    if (intr !== 1'b0) begin errors++; $display("[TB] FAIL reset_intr actual=%b required=0", intr); end
    vectors++;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_read actual=%h required=0", rdata); end
    rst_n = 1'b1;
    in_data = '0;
    irq_src = '0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick(); tick();
  endtask

  task automatic test_out_regs();
    applyStimulus(1'b1, OB + 32'd4, 32'h0000ABCD);
    tick();
    wr = 1'b0;
    vectors++;
    if (out_data !== 48'h0000_ABCD_0000) begin errors++; $display("[TB] FAIL out_write actual=%h required=0000abcd0000", out_data); end
    vectors++;
    if (rdata !== 32'h0000ABCD) begin errors++; $display("[TB] FAIL out_readback actual=%h required=0000abcd", rdata); end
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), pick_addr(), $urandom);
      tick();
      vectors++;
      if (out_data !== m_out) begin errors++; $display("[TB] FAIL out_rand actual=%h required=%h", out_data, m_out); end
      vectors++;
      if (rdata !== exp_read(addr)) begin errors++; $display("[TB] FAIL read_rand addr=%h actual=%h required=%h", addr, rdata, exp_read(addr)); end
    end
    applyStimulus(1'b1, MASK, 32'h0);
    tick();
    wr = 1'b0;
  endtask

  task automatic test_inputs();
    in_data = 32'h1234_0000;
    addr = IB + 32'd4;
    tick();
    vectors++;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL in_early actual=%h required=0", rdata); end
    tick();
    vectors++;
    if (rdata !== 32'h00001234) begin errors++; $display("[TB] FAIL in_sync actual=%h required=00001234", rdata); end
    addr = 32'h11008100;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL unmapped actual=%h required=0", rdata); end
    for (int n = 0; n < 20; n++) begin
      in_data = $urandom;
      addr = ($urandom_range(0, 1) != 0) ? IB : IB + 32'd4;
      tick();
      vectors++;
      if (rdata !== exp_read(addr)) begin errors++; $display("[TB] FAIL in_rand addr=%h actual=%h required=%h", addr, rdata, exp_read(addr)); end
    end
  endtask

  task automatic test_irq_debounce();
    applyStimulus(1'b1, MASK, 32'h1);
    tick();
    applyStimulus(1'b0, STAT, 32'h0);
    irq_src = 5'b00001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (rdata !== ((e >= 7) ? 32'h1 : 32'h0)) begin errors++; $display("[TB] FAIL stat_edge%0d actual=%h required=%h", e, rdata, (e >= 7) ? 1 : 0); end
      vectors++;
      if (intr !== (e >= 8)) begin errors++; $display("[TB] FAIL intr_edge%0d actual=%b required=%b", e, intr, e >= 8); end
    end
    applyStimulus(1'b1, STAT, 32'h1);
    tick();
    wr = 1'b0;
    vectors++;
    if (intr !== 1'b1) begin errors++; $display("[TB] FAIL ack_edge1 actual=%b required=1", intr); end
    tick();
    vectors++;
    if (intr !== 1'b0) begin errors++; $display("[TB] FAIL ack_edge2 actual=%b required=0", intr); end
    irq_src = 5'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL fall_no_set actual=%h required=0", rdata); end
    end
  endtask

  task automatic test_glitch();
    irq_src = 5'b00001;
    tick(); tick(); tick();
    irq_src = 5'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if (rdata !== 32'h0 || intr !== 1'b0) begin errors++; $display("[TB] FAIL glitch stat=%h intr=%b required=0/0", rdata, intr); end
    end
  endtask

  task automatic test_mask_pending();
    applyStimulus(1'b1, MASK, 32'h0);
    tick();
    applyStimulus(1'b0, STAT, 32'h0);
    irq_src = 5'b00100;
    for (int e = 0; e < 8; e++) tick();
    vectors++;
    if (rdata !== 32'h4 || intr !== 1'b0) begin errors++; $display("[TB] FAIL masked_pending stat=%h intr=%b required=4/0", rdata, intr); end
    applyStimulus(1'b1, MASK, 32'h4);
    tick();
    applyStimulus(1'b0, STAT, 32'h0);
    tick();
    vectors++;
    if (intr !== 1'b1) begin errors++; $display("[TB] FAIL unmask_intr actual=%b required=1", intr); end
    irq_src = 5'b0;
    applyStimulus(1'b1, STAT, 32'h4);
    tick();
    wr = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    vectors++;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL w1c_clear actual=%h required=0", rdata); end
    irq_src = 5'b00100;
    for (int e = 0; e < 6; e++) tick();
    applyStimulus(1'b1, STAT, 32'h4);
    tick();
    wr = 1'b0;
    vectors++;
    if (rdata !== 32'h4) begin errors++; $display("[TB] FAIL set_beats_w1c actual=%h required=4", rdata); end
  endtask

  task automatic test_random_irq();
    int r;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) irq_src[i] = ~irq_src[i];
      r = $urandom_range(0, 9);
      if (r == 0)      applyStimulus(1'b1, STAT, $urandom);
      else if (r == 1) applyStimulus(1'b1, MASK, $urandom);
      else             applyStimulus(1'b0, (r < 6) ? STAT : MASK, $urandom);
      tick();
      vectors++;
      if (intr !== m_intr) begin errors++; $display("[TB] FAIL rand_intr actual=%b required=%b", intr, m_intr); end
      vectors++;
      if (rdata !== exp_read(addr)) begin errors++; $display("[TB] FAIL rand_read addr=%h actual=%h required=%h", addr, rdata, exp_read(addr)); end
    end
    wr = 1'b0;
  endtask

  task automatic test_reset_mid();
    irq_src = 5'b00001;
    applyStimulus(1'b1, OB, 32'h5A5A);
    tick();
    applyStimulus(1'b1, MASK, 32'h1);
    tick();
    applyStimulus(1'b1, STAT, 32'h1f);
    tick();
    wr = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    irq_src = 5'b00011;
    for (int e = 0; e < 4; e++) tick();
    vectors++;
    if (intr !== 1'b1 || out_data === 48'h0) begin errors++; $display("[TB] FAIL premid intr=%b out=%h required=1/nonzero", intr, out_data); end
    rst_n = 1'b0;
    applyStimulus(1'b1, OB + 32'd8, 32'hBEEF);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, STAT, 32'h0);
    vectors++;
    if (out_data !== 48'h0 || intr !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset out=%h intr=%b required=0/0", out_data, intr); end
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (rdata !== ((e >= 7) ? 32'h3 : 32'h0)) begin errors++; $display("[TB] FAIL redebounce_edge%0d actual=%h required=%h", e, rdata, (e >= 7) ? 3 : 0); end
      vectors++;
      if (rdata !== exp_read(addr) || intr !== m_intr) begin errors++; $display("[TB] FAIL redebounce_model stat=%h intr=%b required=%h/%b", rdata, intr, exp_read(addr), m_intr); end
    end
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; addr = '0; wdata = '0; in_data = '0; irq_src = '0;
    test_reset();
    test_out_regs();
    test_inputs();
    test_irq_debounce();
    test_glitch();
    test_mask_pending();
    test_random_irq();
    irq_src = '0;
    applyStimulus(1'b1, STAT, 32'h1f);
    tick();
    wr = 1'b0;
    for (int e = 0; e < 10; e++) tick();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/otter_io_bus.md
OTTER_IO_BUS -- requirements
Module: otter_io_bus

Interface
REQ-001 SHALL have parameter N_IN, default 2: number of 32-bit-addressed input ports (1..8).
REQ-002 SHALL have parameter N_OUT, default 3: number of output registers (1..8).
REQ-003 SHALL have parameter DW, default 16: width of each input port and each output register (1..32).
REQ-004 SHALL have parameter N_IRQ, default 5: number of interrupt source lines (1..16).
REQ-005 SHALL have parameter DB_CYCLES, default 5: debounce length in clocks (2..255).
REQ-006 SHALL have parameters IN_BASE, default 32'h11008000, and OUT_BASE, default 32'h1100C000: address bases.
REQ-007 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-008 SHALL have port RST_N, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port iobus_addr, input, 32: CPU I/O address.
REQ-010 SHALL have port iobus_out, input, 32: CPU write data.
REQ-011 SHALL have port iobus_wr, input, 1: CPU write strobe, one cycle per write.
REQ-012 SHALL have port iobus_in, output, 32: read data to CPU.
REQ-013 SHALL have port in_data, input, N_IN*DW: asynchronous board inputs; port k is bits [k*DW +: DW].
REQ-014 SHALL have port irq_src, input, N_IRQ: asynchronous interrupt sources (buttons).
REQ-015 SHALL have port out_data, output, N_OUT*DW: output registers; register k is bits [k*DW +: DW].
REQ-016 SHALL have port intr, output, 1: registered interrupt request to the MCU.

Function
REQ-017 SHALL use the address map: IN_BASE+4k reads synced input k; IN_BASE+4*N_IN is IRQ_STAT (read, write-1-to-clear); OUT_BASE+4k is output register k (read/write); OUT_BASE+4*N_OUT is IRQ_MASK (read/write, low N_IRQ bits).
REQ-018 SHALL drive iobus_in combinationally from iobus_addr, zero-extended to 32 bits; unmapped addresses SHALL read 32'h0.
REQ-019 SHALL update a register on the rising edge where iobus_wr=1 and the address matches; the new value SHALL appear on out_data and in readback the following cycle. Writes to unmapped or read-only input addresses SHALL be ignored.
REQ-020 SHALL pass every in_data and irq_src bit through a 2-flop synchronizer; a change settled before edge 0 SHALL be readable after edge 2.
REQ-021 SHALL debounce each IRQ channel with its own counter: counter clears when synced level equals debounced level, else increments; when it reaches DB_CYCLES-1 with the levels still differing, the debounced level SHALL toggle and the counter clear on that edge.
REQ-022 SHALL set IRQ_STAT bit i on the edge where debounced i toggles 0->1; falling toggles SHALL NOT set or clear status.
REQ-023 SHALL clear IRQ_STAT bits written as 1 to IRQ_STAT; bits written 0 SHALL be unchanged.
REQ-024 SHALL let a set event win over a simultaneous W1C on the same bit.
REQ-025 SHALL register intr <= |(IRQ_STAT & IRQ_MASK), so intr is a level held until acknowledged or masked, one cycle after its cause.
REQ-026 SHALL latch pending status regardless of mask; unmasking a pending bit SHALL assert intr on the next edge.
REQ-027 SHALL add no latency between out_data and the registers; no combinational path from iobus_* to out_data or intr.

Reset
REQ-028 SHALL, on any edge with RST_N=0, clear all output registers, IRQ_STAT, IRQ_MASK, synchronizers, debounced levels, counters and intr to 0, including mid-debounce and during a concurrent write (reset wins).
REQ-029 SHALL keep iobus_in combinational during reset, reading the cleared state.

Verification
REQ-030 Write 32'h0000ABCD to OUT_BASE+4 (N_OUT=3, DW=16) -> out_data[31:16]=16'hABCD next cycle; read OUT_BASE+4 returns 32'h0000ABCD; other registers 0.
REQ-031 in_data port 1 set to 16'h1234 -> read IN_BASE+4 returns 32'h00001234 from edge 2 on; read 32'h11008100 returns 0.
REQ-032 IRQ_MASK=5'b00001, irq_src[0] rises before edge 0 and holds (DB_CYCLES=5) -> IRQ_STAT=1 at edge 7, intr=1 at edge 8; write 1 to IRQ_STAT -> intr=0 two edges later.
REQ-033 irq_src[0] pulses high for 3 cycles (< DB_CYCLES) -> IRQ_STAT stays 0, intr stays 0.
REQ-034 irq_src[2] debounced with mask 0 -> IRQ_STAT=5'b00100, intr=0; write IRQ_MASK=5'b00100 -> intr=1 next edge; W1C on the same edge as a new set -> bit stays 1.
REQ-035 RST_N=0 for one edge mid-debounce, with out_data nonzero and intr=1 -> all outputs 0 next cycle; source must re-debounce a full DB_CYCLES after release.
